// File: rtl/rocc_acc_pkg.sv
// Shared types for the multi-slot RoCC latency accelerator.
// The slot counter width is fixed here because slot_t carries the counter.
package rocc_acc_pkg;

  localparam int SLOT_CNT_WIDTH = 16;

  typedef enum logic [6:0] {
    FN_CFG_WR = 7'd0,
    FN_CFG_RD = 7'd1,
    FN_EXEC   = 7'd2
  } funct_e;

  typedef struct packed {
    logic                      busy;
    logic                      done;
    logic                      xd;
    logic [4:0]                rd;
    logic [63:0]               data;
    logic [SLOT_CNT_WIDTH-1:0] cnt;
  } slot_t;

  // A programmed latency of zero still costs one countdown cycle.
  function automatic logic [SLOT_CNT_WIDTH-1:0] clamp_latency(
    input logic [SLOT_CNT_WIDTH-1:0] lat
  );
    return (lat == '0) ? SLOT_CNT_WIDTH'(1) : lat;
  endfunction

endpackage

// File: rtl/rocc_acc_slot.sv
// One in-flight command: loads a result and countdown, raises done when the
// countdown expires, and is released by the response stage (or on its own if xd=0).
module rocc_acc_slot
  import rocc_acc_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      load,
  input  logic                      load_xd,
  input  logic [4:0]                load_rd,
  input  logic [63:0]               load_data,
  input  logic [SLOT_CNT_WIDTH-1:0] load_cnt,
  input  logic                      take,
  output logic                      busy,
  output logic                      done,
  output logic [4:0]                rd,
  output logic [63:0]               data
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (slot_q.busy && !slot_q.done) begin
      if (slot_q.cnt <= SLOT_CNT_WIDTH'(1)) begin
        slot_d.cnt = '0;
        // Fire-and-forget commands release the slot instead of waiting for the stage.
        if (slot_q.xd) begin
          slot_d.done = 1'b1;
        end else begin
          slot_d.busy = 1'b0;
        end
      end else begin
        slot_d.cnt = slot_q.cnt - SLOT_CNT_WIDTH'(1);
      end
    end
    if (take) begin
      slot_d.busy = 1'b0;
      slot_d.done = 1'b0;
    end
    if (load) begin
      slot_d.busy = 1'b1;
      slot_d.done = 1'b0;
      slot_d.xd   = load_xd;
      slot_d.rd   = load_rd;
      slot_d.data = load_data;
      slot_d.cnt  = load_cnt;
    end
    if (clear) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign busy = slot_q.busy;
  assign done = slot_q.busy & slot_q.done;
  assign rd   = slot_q.rd;
  assign data = slot_q.data;

endmodule

// File: rtl/rocc_multislot_acc.sv
// RoCC accelerator model with NUM_SLOTS concurrent commands, a config register
// file that sets EXEC latency, and a registered response stage.
module rocc_multislot_acc
  import rocc_acc_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int NUM_CFG_REGS    = 4,
  parameter int CFG_REG_WIDTH   = 32,
  parameter int CNT_WIDTH       = 16,
  parameter int DEFAULT_LATENCY = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic [6:0]  io_cmd_bits_inst_funct,
  input  logic [4:0]  io_cmd_bits_inst_rd,
  input  logic        io_cmd_bits_inst_xd,
  input  logic [63:0] io_cmd_bits_rs1,
  input  logic [63:0] io_cmd_bits_rs2,
  input  logic        io_resp_ready,
  output logic        io_resp_valid,
  output logic [4:0]  io_resp_bits_rd,
  output logic [63:0] io_resp_bits_data,
  output logic        io_busy,
  output logic        io_interrupt,
  input  logic        io_exception,
  output logic        io_mem_req_valid,
  output logic [39:0] io_mem_req_bits_addr,
  output logic [7:0]  io_mem_req_bits_tag,
  output logic [4:0]  io_mem_req_bits_cmd,
  output logic [1:0]  io_mem_req_bits_size,
  output logic        io_mem_req_bits_signed,
  output logic [63:0] io_mem_req_bits_data,
  output logic        io_mem_s1_kill,
  output logic        io_mem_s2_kill,
  output logic        io_mem_keep_clock_enabled,
  input  logic        io_mem_req_ready,
  input  logic        io_mem_resp_valid,
  input  logic [63:0] io_mem_resp_bits_data,
  output logic        io_fpu_req_valid,
  output logic        io_fpu_resp_ready,
  input  logic        io_fpu_req_ready,
  input  logic        io_fpu_resp_valid,
  input  logic [63:0] io_fpu_resp_bits_data
);

  localparam int SLOT_IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [NUM_SLOTS-1:0]      slot_busy;
  logic [NUM_SLOTS-1:0]      slot_done;
  logic [NUM_SLOTS-1:0]      slot_load;
  logic [NUM_SLOTS-1:0]      slot_take;
  logic [4:0]                slot_rd   [NUM_SLOTS];
  logic [63:0]               slot_data [NUM_SLOTS];

  logic [CFG_REG_WIDTH-1:0]  cfg_q [NUM_CFG_REGS];
  logic [CFG_REG_WIDTH-1:0]  cfg_d [NUM_CFG_REGS];

  logic                      resp_valid_q, resp_valid_d;
  logic [4:0]                resp_rd_q, resp_rd_d;
  logic [63:0]               resp_data_q, resp_data_d;
  logic                      interrupt_q, interrupt_d;

  logic [SLOT_IDX_W-1:0]     alloc_idx;
  logic [SLOT_IDX_W-1:0]     resp_sel;
  logic                      done_found;
  logic                      is_wr, is_rd, is_exec, is_legal;
  logic                      cmd_fire, stage_free, resp_load;
  logic [63:0]               cfg_rd_val;
  logic [63:0]               load_data;
  logic [SLOT_CNT_WIDTH-1:0] load_cnt;

  assign io_cmd_ready = ~&slot_busy;
  assign cmd_fire     = io_cmd_valid & io_cmd_ready & ~io_exception;

  // Lowest-index free slot for allocation, lowest-index done slot for response.
  always_comb begin
    alloc_idx  = '0;
    resp_sel   = '0;
    done_found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) alloc_idx = SLOT_IDX_W'(i);
      if (slot_done[i]) begin
        resp_sel   = SLOT_IDX_W'(i);
        done_found = 1'b1;
      end
    end
  end

  always_comb begin
    is_wr   = 1'b0;
    is_rd   = 1'b0;
    is_exec = 1'b0;
    case (io_cmd_bits_inst_funct)
      FN_CFG_WR: is_wr   = 1'b1;
      FN_CFG_RD: is_rd   = 1'b1;
      FN_EXEC:   is_exec = 1'b1;
      default:   ;
    endcase
  end
  assign is_legal = is_wr | is_rd | is_exec;

  always_comb begin
    cfg_rd_val = '0;
    for (int i = 0; i < NUM_CFG_REGS; i++) begin
      cfg_d[i] = cfg_q[i];
      if (io_cmd_bits_rs1 == 64'(i)) begin
        cfg_rd_val = 64'(cfg_q[i]);
        if (cmd_fire && is_wr) cfg_d[i] = io_cmd_bits_rs2[CFG_REG_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    load_data = '0;
    load_cnt  = SLOT_CNT_WIDTH'(1);
    if (is_exec) begin
      load_data = io_cmd_bits_rs1 + io_cmd_bits_rs2;
      load_cnt  = clamp_latency(SLOT_CNT_WIDTH'(cfg_q[0][CNT_WIDTH-1:0]));
    end else if (is_rd) begin
      load_data = cfg_rd_val;
    end
  end

  assign stage_free = ~resp_valid_q | io_resp_ready;
  assign resp_load  = stage_free & done_found & ~io_exception;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign slot_load[gi] = cmd_fire & is_legal & (alloc_idx == SLOT_IDX_W'(gi));
      assign slot_take[gi] = resp_load & (resp_sel == SLOT_IDX_W'(gi));

      rocc_acc_slot u_slot (
        .clock     (clock),
        .reset     (reset),
        .clear     (io_exception),
        .load      (slot_load[gi]),
        .load_xd   (io_cmd_bits_inst_xd),
        .load_rd   (io_cmd_bits_inst_rd),
        .load_data (load_data),
        .load_cnt  (load_cnt),
        .take      (slot_take[gi]),
        .busy      (slot_busy[gi]),
        .done      (slot_done[gi]),
        .rd        (slot_rd[gi]),
        .data      (slot_data[gi])
      );
    end
  endgenerate

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_rd_d    = resp_rd_q;
    resp_data_d  = resp_data_q;
    interrupt_d  = cmd_fire & ~is_legal;
    if (io_exception) begin
      resp_valid_d = 1'b0;
      resp_rd_d    = '0;
      resp_data_d  = '0;
    end else if (stage_free) begin
      resp_valid_d = done_found;
      if (done_found) begin
        resp_rd_d   = slot_rd[resp_sel];
        resp_data_d = slot_data[resp_sel];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      interrupt_q  <= 1'b0;
      for (int i = 0; i < NUM_CFG_REGS; i++) begin
        cfg_q[i] <= (i == 0) ? CFG_REG_WIDTH'(DEFAULT_LATENCY) : '0;
      end
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      interrupt_q  <= interrupt_d;
      cfg_q        <= cfg_d;
    end
  end

  assign io_resp_valid     = resp_valid_q;
  assign io_resp_bits_rd   = resp_rd_q;
  assign io_resp_bits_data = resp_data_q;
  assign io_interrupt      = interrupt_q;
  assign io_busy           = (|slot_busy) | resp_valid_q;

  assign io_mem_req_valid          = 1'b0;
  assign io_mem_req_bits_addr      = '0;
  assign io_mem_req_bits_tag       = '0;
  assign io_mem_req_bits_cmd       = '0;
  assign io_mem_req_bits_size      = '0;
  assign io_mem_req_bits_signed    = 1'b0;
  assign io_mem_req_bits_data      = '0;
  assign io_mem_s1_kill            = 1'b0;
  assign io_mem_s2_kill            = 1'b0;
  assign io_mem_keep_clock_enabled = 1'b1;
  assign io_fpu_req_valid          = 1'b0;
  assign io_fpu_resp_ready         = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{io_mem_req_ready, io_mem_resp_valid, io_mem_resp_bits_data,
                       io_fpu_req_ready, io_fpu_resp_valid, io_fpu_resp_bits_data};

endmodule

// File: tb/tb_rocc_multislot_acc.sv
// Directed and randomized bench for rocc_multislot_acc; expected responses come
// from a cfg-array/scoreboard model of the command semantics.
module tb_rocc_multislot_acc;

  logic        clock, reset;
  logic        io_cmd_valid, io_cmd_ready;
  logic [6:0]  io_cmd_bits_inst_funct;
  logic [4:0]  io_cmd_bits_inst_rd;
  logic        io_cmd_bits_inst_xd;
  logic [63:0] io_cmd_bits_rs1, io_cmd_bits_rs2;
  logic        io_resp_ready, io_resp_valid;
  logic [4:0]  io_resp_bits_rd;
  logic [63:0] io_resp_bits_data;
  logic        io_busy, io_interrupt, io_exception;
  logic        io_mem_req_valid;
  logic [39:0] io_mem_req_bits_addr;
  logic [7:0]  io_mem_req_bits_tag;
  logic [4:0]  io_mem_req_bits_cmd;
  logic [1:0]  io_mem_req_bits_size;
  logic        io_mem_req_bits_signed;
  logic [63:0] io_mem_req_bits_data;
  logic        io_mem_s1_kill, io_mem_s2_kill, io_mem_keep_clock_enabled;
  logic        io_fpu_req_valid, io_fpu_resp_ready;

  rocc_multislot_acc dut (
    .clock(clock), .reset(reset),
    .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_bits_inst_funct(io_cmd_bits_inst_funct), .io_cmd_bits_inst_rd(io_cmd_bits_inst_rd),
    .io_cmd_bits_inst_xd(io_cmd_bits_inst_xd),
    .io_cmd_bits_rs1(io_cmd_bits_rs1), .io_cmd_bits_rs2(io_cmd_bits_rs2),
    .io_resp_ready(io_resp_ready), .io_resp_valid(io_resp_valid),
    .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
    .io_busy(io_busy), .io_interrupt(io_interrupt), .io_exception(io_exception),
    .io_mem_req_valid(io_mem_req_valid), .io_mem_req_bits_addr(io_mem_req_bits_addr),
    .io_mem_req_bits_tag(io_mem_req_bits_tag), .io_mem_req_bits_cmd(io_mem_req_bits_cmd),
    .io_mem_req_bits_size(io_mem_req_bits_size), .io_mem_req_bits_signed(io_mem_req_bits_signed),
    .io_mem_req_bits_data(io_mem_req_bits_data), .io_mem_s1_kill(io_mem_s1_kill),
    .io_mem_s2_kill(io_mem_s2_kill), .io_mem_keep_clock_enabled(io_mem_keep_clock_enabled),
    .io_mem_req_ready(1'b0), .io_mem_resp_valid(1'b0), .io_mem_resp_bits_data(64'd0),
    .io_fpu_req_valid(io_fpu_req_valid), .io_fpu_resp_ready(io_fpu_resp_ready),
    .io_fpu_req_ready(1'b0), .io_fpu_resp_valid(1'b0), .io_fpu_resp_bits_data(64'd0)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int          earliest;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        sb[$];
  logic [31:0] cfg_m [4];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [6:0] f, input logic [4:0] rd, input logic xd,
                      input logic [63:0] a, input logic [63:0] b, output int acc);
    int w;
    io_cmd_valid = 1'b1;
    io_cmd_bits_inst_funct = f;
    io_cmd_bits_inst_rd = rd;
    io_cmd_bits_inst_xd = xd;
    io_cmd_bits_rs1 = a;
    io_cmd_bits_rs2 = b;
    w = 0;
    while (!io_cmd_ready && w < 200) begin
      tick();
      w++;
    end
    chk("send_ready", 64'(io_cmd_ready), 64'd1);
    tick();
    io_cmd_valid = 1'b0;
    acc = cyc;
    $display("cmd funct=%0d rd=%0d xd=%0d rs1=0x%0h rs2=0x%0h accepted cyc=%0d", f, rd, xd, a, b, acc);
  endtask

  task automatic wait_resp(input int acc, output int lat);
    int w;
    w = 0;
    while (!io_resp_valid && w < 200) begin
      tick();
      w++;
    end
    chk("resp_valid_seen", 64'(io_resp_valid), 64'd1);
    lat = cyc - acc;
    $display("resp rd=%0d data=0x%0h latency=%0d", io_resp_bits_rd, io_resp_bits_data, lat);
  endtask

  task automatic pulse_ready();
    io_resp_ready = 1'b1;
    tick();
    io_resp_ready = 1'b0;
  endtask

  // Called when the current response will transfer at the next edge.
  task automatic sb_match();
    int idx;
    idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].rd == io_resp_bits_rd) idx = i;
    chk("sb_tag_known", 64'(idx >= 0), 64'd1);
    if (idx >= 0) begin
      chk("sb_data", io_resp_bits_data, sb[idx].data);
      chk("sb_latency_min", 64'(cyc >= sb[idx].earliest), 64'd1);
      $display("resp rd=%0d data=0x%0h cyc=%0d", io_resp_bits_rd, io_resp_bits_data, cyc);
      sb.delete(idx);
    end
  endtask

  task automatic drain(input int budget);
    int w;
    io_resp_ready = 1'b1;
    w = 0;
    while (sb.size() > 0 && w < budget) begin
      if (io_resp_valid) sb_match();
      tick();
      w++;
    end
    io_resp_ready = 1'b0;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic no_resp_for(input string tag, input int n);
    int stray;
    stray = 0;
    for (int i = 0; i < n; i++) begin
      if (io_resp_valid) stray++;
      tick();
    end
    chk(tag, 64'(stray), 64'd0);
  endtask

  initial begin
    int acc, acc1, acc5, lat, accepted, w, r, lat_m, tag_ctr;
    logic irq_exp;
    logic [63:0] a, b;
    logic [6:0]  f;

    io_cmd_valid = 0; io_cmd_bits_inst_funct = 0; io_cmd_bits_inst_rd = 0;
    io_cmd_bits_inst_xd = 0; io_cmd_bits_rs1 = 0; io_cmd_bits_rs2 = 0;
    io_resp_ready = 0; io_exception = 0;
    reset = 1;
    repeat (3) tick();
    reset = 0;

    // 1: reset state and cfg[0] readback
    chk("rst_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("rst_busy", 64'(io_busy), 64'd0);
    chk("rst_interrupt", 64'(io_interrupt), 64'd0);
    chk("rst_cmd_ready", 64'(io_cmd_ready), 64'd1);
    chk("rst_resp_rd", 64'(io_resp_bits_rd), 64'd0);
    chk("rst_resp_data", io_resp_bits_data, 64'd0);
    chk("rst_keep_clk", 64'(io_mem_keep_clock_enabled), 64'd1);
    chk("rst_mem_req", 64'(io_mem_req_valid), 64'd0);
    send(7'd1, 5'd3, 1'b1, 64'd0, 64'd0, acc);
    wait_resp(acc, lat);
    chk("t1_rd", 64'(io_resp_bits_rd), 64'd3);
    chk("t1_data", io_resp_bits_data, 64'd16);
    chk("t1_latency", 64'(lat), 64'd2);
    pulse_ready();

    // 2: CFG_WR followed immediately by EXEC picks up new latency
    send(7'd0, 5'd1, 1'b0, 64'd0, 64'd5, acc);
    send(7'd2, 5'd9, 1'b1, 64'd7, 64'd8, acc);
    wait_resp(acc, lat);
    chk("t2_rd", 64'(io_resp_bits_rd), 64'd9);
    chk("t2_data", io_resp_bits_data, 64'd15);
    chk("t2_latency", 64'(lat), 64'd6);
    pulse_ready();
    send(7'd0, 5'd1, 1'b0, 64'd4, 64'd99, acc);   // out-of-range write ignored
    send(7'd1, 5'd2, 1'b1, 64'd0, 64'd0, acc);
    wait_resp(acc, lat);
    chk("t2_cfg0_kept", io_resp_bits_data, 64'd5);
    pulse_ready();
    send(7'd0, 5'd1, 1'b0, 64'd2, 64'hFFFF_FFFF_DEAD_BEEF, acc);
    send(7'd1, 5'd4, 1'b1, 64'd2, 64'd0, acc);
    wait_resp(acc, lat);
    chk("t2_cfg2_trunc", io_resp_bits_data, 64'hDEAD_BEEF);
    pulse_ready();
    send(7'd1, 5'd5, 1'b1, 64'd9, 64'd0, acc);
    wait_resp(acc, lat);
    chk("t2_cfg_oob_rd", io_resp_bits_data, 64'd0);
    pulse_ready();

    // 3: five EXECs with resp_ready low; a slot frees when its result enters the stage
    for (int i = 0; i < 4; i++) begin
      send(7'd2, 5'(12 + i), 1'b1, 64'(100 * i), 64'd1, acc);
      if (i == 0) acc1 = acc;
      sb.push_back('{5'(12 + i), 64'(100 * i + 1), 0});
    end
    chk("t3_ready_full", 64'(io_cmd_ready), 64'd0);
    send(7'd2, 5'd16, 1'b1, 64'd400, 64'd1, acc5);
    sb.push_back('{5'd16, 64'd401, 0});
    chk("t3_fifth_accept", 64'(acc5 - acc1), 64'd7);
    drain(200);
    tick();
    chk("t3_idle", 64'(io_busy), 64'd0);

    // 4: response held stable under backpressure
    send(7'd2, 5'd20, 1'b1, 64'd100, 64'd23, acc);
    wait_resp(acc, lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", 64'(io_resp_valid), 64'd1);
      chk("t4_hold_rd", 64'(io_resp_bits_rd), 64'd20);
      chk("t4_hold_data", io_resp_bits_data, 64'd123);
    end
    pulse_ready();
    chk("t4_single_xfer", 64'(io_resp_valid), 64'd0);
    chk("t4_idle", 64'(io_busy), 64'd0);

    // 5: illegal funct interrupt, then zero latency treated as one
    chk("t5_irq_before", 64'(io_interrupt), 64'd0);
    send(7'd7, 5'd6, 1'b1, 64'd0, 64'd0, acc);
    chk("t5_irq_pulse", 64'(io_interrupt), 64'd1);
    tick();
    chk("t5_irq_clear", 64'(io_interrupt), 64'd0);
    no_resp_for("t5_no_resp", 5);
    chk("t5_idle", 64'(io_busy), 64'd0);
    send(7'd0, 5'd1, 1'b0, 64'd0, 64'd0, acc);
    send(7'd2, 5'd11, 1'b1, 64'd1, 64'd2, acc);
    wait_resp(acc, lat);
    chk("t5_l0_latency", 64'(lat), 64'd2);
    chk("t5_l0_data", io_resp_bits_data, 64'd3);
    chk("t5_l0_rd", 64'(io_resp_bits_rd), 64'd11);
    pulse_ready();

    // 6a: exception aborts work, drops concurrent command, keeps cfg
    send(7'd0, 5'd1, 1'b0, 64'd0, 64'd20, acc);
    for (int i = 0; i < 3; i++) send(7'd2, 5'(21 + i), 1'b1, 64'(i), 64'd1, acc);
    chk("t6_busy", 64'(io_busy), 64'd1);
    io_cmd_valid = 1; io_cmd_bits_inst_funct = 7'd0; io_cmd_bits_inst_xd = 1;
    io_cmd_bits_rs1 = 64'd0; io_cmd_bits_rs2 = 64'd3; io_exception = 1;
    tick();
    io_cmd_valid = 0; io_exception = 0;
    chk("t6_exc_busy", 64'(io_busy), 64'd0);
    chk("t6_exc_valid", 64'(io_resp_valid), 64'd0);
    chk("t6_exc_ready", 64'(io_cmd_ready), 64'd1);
    no_resp_for("t6_exc_no_resp", 30);
    send(7'd1, 5'd4, 1'b1, 64'd0, 64'd0, acc);
    wait_resp(acc, lat);
    chk("t6_cfg_kept", io_resp_bits_data, 64'd20);
    pulse_ready();

    // 6b: reset mid-flight restores defaults
    for (int i = 0; i < 3; i++) send(7'd2, 5'(24 + i), 1'b1, 64'(i), 64'd1, acc);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_rst_busy", 64'(io_busy), 64'd0);
    chk("t6_rst_valid", 64'(io_resp_valid), 64'd0);
    no_resp_for("t6_rst_no_resp", 30);
    send(7'd1, 5'd4, 1'b1, 64'd0, 64'd0, acc);
    wait_resp(acc, lat);
    chk("t6_rst_cfg0", io_resp_bits_data, 64'd16);
    pulse_ready();

    // 7: randomized traffic against the cfg/scoreboard model
    cfg_m[0] = 32'd16; cfg_m[1] = 0; cfg_m[2] = 0; cfg_m[3] = 0;
    accepted = 0; w = 0; irq_exp = 0; tag_ctr = 0;
    while (accepted < 60 && w < 4000) begin
      chk("rnd_irq", 64'(io_interrupt), 64'(irq_exp));
      irq_exp = 0;
      io_resp_ready = ($urandom_range(0, 3) != 0);
      io_cmd_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      f = (r < 2) ? 7'd0 : (r < 4) ? 7'd1 : (r < 9) ? 7'd2 : 7'($urandom_range(3, 127));
      io_cmd_bits_inst_funct = f;
      io_cmd_bits_inst_rd = 5'(tag_ctr);
      tag_ctr++;
      io_cmd_bits_inst_xd = ($urandom_range(0, 4) != 0);
      if (f == 7'd2) begin
        io_cmd_bits_rs1 = {$urandom, $urandom};
        io_cmd_bits_rs2 = {$urandom, $urandom};
      end else begin
        io_cmd_bits_rs1 = 64'($urandom_range(0, 5));
        io_cmd_bits_rs2 = (io_cmd_bits_rs1 == 0) ? 64'($urandom_range(0, 6)) : {$urandom, $urandom};
      end
      if (io_resp_valid && io_resp_ready) sb_match();
      if (io_cmd_valid && io_cmd_ready) begin
        a = io_cmd_bits_rs1;
        b = io_cmd_bits_rs2;
        accepted++;
        $display("cmd funct=%0d rd=%0d xd=%0d rs1=0x%0h rs2=0x%0h cyc=%0d", f, io_cmd_bits_inst_rd,
                 io_cmd_bits_inst_xd, a, b, cyc + 1);
        if (f == 7'd0) begin
          if (a < 4) cfg_m[a[1:0]] = b[31:0];
          if (io_cmd_bits_inst_xd) sb.push_back('{io_cmd_bits_inst_rd, 64'd0, cyc + 3});
        end else if (f == 7'd1) begin
          if (io_cmd_bits_inst_xd)
            sb.push_back('{io_cmd_bits_inst_rd, (a < 4) ? 64'(cfg_m[a[1:0]]) : 64'd0, cyc + 3});
        end else if (f == 7'd2) begin
          lat_m = int'(cfg_m[0] % 65536);
          if (lat_m == 0) lat_m = 1;
          if (io_cmd_bits_inst_xd) sb.push_back('{io_cmd_bits_inst_rd, a + b, cyc + lat_m + 2});
        end else begin
          irq_exp = 1;
        end
      end
      tick();
      w++;
    end
    io_cmd_valid = 0;
    chk("rnd_irq_last", 64'(io_interrupt), 64'(irq_exp));
    chk("rnd_accepted", 64'(accepted), 64'd60);
    drain(1000);
    tick();
    chk("rnd_idle", 64'(io_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
